// File: rtl/soc_pkg.sv
// Shared definitions for the load strobe front end: FSM state encoding and
// synchronizer depth.
package soc_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    STROBE       = 3'd2,
    HELD         = 3'd3,
    RELEASE_WAIT = 3'd4
  } state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Multi-bit flop-chain synchronizer for asynchronous board inputs.
// Latency: SYNC_STAGES clock cycles.
// Reset loads RST_VAL into every stage so downstream logic sees a defined value.
module sync_2ff
  import soc_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  // Shift the raw input through the flop chain; each bit is synchronized independently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/load_strobe_gen.sv
// Pushbutton-to-load-strobe converter: synchronize, debounce, capture switches,
// emit one one-hot Load pulse per press to a round-robin selected register.
// Macro LOAD_STROBE_DEBOUNCE_EN enables debounce; without it key edges act immediately.
module load_strobe_gen
  import soc_pkg::*;
#(
  parameter int DATA_W          = 4,
  parameter int NUM_REGS        = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        KeyN,
  input  logic [DATA_W-1:0]           Switches,
  output logic [DATA_W-1:0]           DataOut,
  output logic [NUM_REGS-1:0]         Load,
  output logic [$clog2(NUM_REGS)-1:0] SelIndex,
  output logic                        Busy
);

  localparam int SEL_W = $clog2(NUM_REGS);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_REGS - 1);

  logic              key_s;
  logic [DATA_W-1:0] sw_s;
  state_t            state;

`ifdef LOAD_STROBE_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [CNT_W-1:0] cnt;
`endif

  // Key idles released (1) so reset never looks like a press.
  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_key_sync (
    .clk (Clock),
    .rst (Reset),
    .d   (KeyN),
    .q   (key_s)
  );

  sync_2ff #(.WIDTH(DATA_W), .RST_VAL('0)) u_sw_sync (
    .clk (Clock),
    .rst (Reset),
    .d   (Switches),
    .q   (sw_s)
  );

  // Press/release FSM with registered outputs. DataOut is captured on the edge
  // entering STROBE; Load is registered from STROBE, so it rises one cycle after
  // the capture, and SelIndex advances on that same edge (pulse uses old index).
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      DataOut  <= '0;
      Load     <= '0;
      SelIndex <= '0;
      Busy     <= 1'b0;
`ifdef LOAD_STROBE_DEBOUNCE_EN
      cnt      <= '0;
`endif
    end else begin
      Load <= '0;
      case (state)
        IDLE: begin
          if (!key_s) begin
            Busy <= 1'b1;
`ifdef LOAD_STROBE_DEBOUNCE_EN
            state <= PRESS_WAIT;
            cnt   <= '0;
`else
            DataOut <= sw_s;
            state   <= STROBE;
`endif
          end
        end

`ifdef LOAD_STROBE_DEBOUNCE_EN
        PRESS_WAIT: begin
          if (key_s) begin
            state <= IDLE;
            Busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            DataOut <= sw_s;
            state   <= STROBE;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        STROBE: begin
          Load     <= NUM_REGS'(1) << SelIndex;
          SelIndex <= (SelIndex == SEL_LAST) ? '0 : SelIndex + 1'b1;
          state    <= HELD;
        end

        HELD: begin
          if (key_s) begin
`ifdef LOAD_STROBE_DEBOUNCE_EN
            state <= RELEASE_WAIT;
            cnt   <= '0;
`else
            state <= IDLE;
            Busy  <= 1'b0;
`endif
          end
        end

`ifdef LOAD_STROBE_DEBOUNCE_EN
        RELEASE_WAIT: begin
          if (!key_s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            Busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_strobe_gen.sv
// Scoreboard bench for load_strobe_gen: presses push expected pulses, a negedge
// monitor pops and checks each Load pulse (timing, target, data, setup, index).
// Runs in either build; bounce scenarios only apply when debounce is enabled.
module tb_load_strobe_gen;

  localparam int DW = 4;
  localparam int NR = 4;
  localparam int DC = 16;
`ifdef LOAD_STROBE_DEBOUNCE_EN
  localparam int LAT = DC + 3;
`else
  localparam int LAT = 3;
`endif
  localparam int GAP = 2 * DC + 10;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          KeyN;
  logic [DW-1:0] Switches;
  logic [DW-1:0] DataOut;
  logic [NR-1:0] Load;
  logic [1:0]    SelIndex;
  logic          Busy;

  load_strobe_gen #(.DATA_W(DW), .NUM_REGS(NR), .DEBOUNCE_CYCLES(DC)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .KeyN     (KeyN),
    .Switches (Switches),
    .DataOut  (DataOut),
    .Load     (Load),
    .SelIndex (SelIndex),
    .Busy     (Busy)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int            t;
    logic [NR-1:0] load;
    logic [DW-1:0] dat;
    logic [1:0]    sel;
  } exp_t;

  exp_t       q[$];
  int         tests = 0;
  int         fails = 0;
  logic [1:0] sel_m = 2'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every Load pulse must match the head of the expected queue.
  initial begin : monitor
    logic [DW-1:0] prev_dout;
    exp_t          e;
    prev_dout = '0;
    forever begin
      @(negedge Clock);
      if (q.size() > 0 && cyc > q[0].t) begin
        chk("pulse_missing", cyc, q[0].t);
        void'(q.pop_front());
      end
      if (Load !== '0) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", Load, 0);
        end else begin
          e = q.pop_front();
          chk("pulse_time", cyc, e.t);
          chk("pulse_load", Load, e.load);
          chk("pulse_dout", DataOut, e.dat);
          chk("dout_setup", prev_dout, e.dat);
          chk("sel_after", SelIndex, e.sel);
        end
      end
      prev_dout = DataOut;
    end
  end

  function automatic logic [1:0] next_sel(input logic [1:0] s);
    return (s == 2'(NR - 1)) ? 2'd0 : s + 2'd1;
  endfunction

  // Clean press: optional switch change at hold cycle 30 (after the pulse).
  task automatic press(input logic [DW-1:0] sw, input logic [DW-1:0] sw2, input int hold);
    @(negedge Clock);
    Switches = sw;
    KeyN     = 1'b0;
    q.push_back('{cyc + 1 + LAT, NR'(1) << sel_m, sw, next_sel(sel_m)});
    sel_m = next_sel(sel_m);
    for (int i = 0; i < hold; i++) begin
      @(negedge Clock);
      if (i == 30) Switches = sw2;
    end
    chk("busy_held", Busy, 1);
    KeyN = 1'b1;
    repeat (GAP) @(negedge Clock);
    chk("busy_idle", Busy, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  initial begin : stim
    Reset    = 1'b1;
    KeyN     = 1'b1;
    Switches = '0;
    repeat (3) @(negedge Clock);
    chk("rst_load", Load, 0);
    chk("rst_busy", Busy, 0);
    Reset = 1'b0;

    // Idle with key released: nothing moves.
    for (int i = 0; i < 5; i++) begin
      repeat (10) @(negedge Clock);
      chk("idle_load", Load, 0);
      chk("idle_dout", DataOut, 0);
      chk("idle_sel", SelIndex, 0);
      chk("idle_busy", Busy, 0);
    end

    // Clean press with 4'hA held 100 cycles.
    press(4'hA, 4'hA, 100);
    chk("sel_after_first", SelIndex, 1);

`ifdef LOAD_STROBE_DEBOUNCE_EN
    // Bouncing press: 5 short lows, then stable; bouncing release.
    @(negedge Clock);
    Switches = 4'h6;
    for (int b = 0; b < 5; b++) begin
      KeyN = 1'b0;
      repeat (3) @(negedge Clock);
      KeyN = 1'b1;
      repeat (3) @(negedge Clock);
    end
    KeyN = 1'b0;
    q.push_back('{cyc + 1 + LAT, NR'(1) << sel_m, 4'h6, next_sel(sel_m)});
    sel_m = next_sel(sel_m);
    repeat (40) @(negedge Clock);
    for (int b = 0; b < 3; b++) begin
      KeyN = 1'b1;
      repeat (3) @(negedge Clock);
      KeyN = 1'b0;
      repeat (3) @(negedge Clock);
    end
    KeyN = 1'b1;
    repeat (GAP) @(negedge Clock);
    chk("bounce_dout", DataOut, 4'h6);
`endif

    // Five presses exercise round-robin wrap.
    for (int k = 1; k <= 5; k++) press(DW'(k), DW'(k), 40);

    // Switch change while held must not reach DataOut.
    press(4'h3, 4'hC, 60);
    chk("dout_hold", DataOut, 4'h3);

    // Reset while Load is high.
    @(negedge Clock);
    Switches = 4'h9;
    KeyN     = 1'b0;
    repeat (LAT + 1) @(posedge Clock);
    #2;
    chk("pre_reset_load", Load, NR'(1) << sel_m);
    Reset = 1'b1;
    KeyN  = 1'b1;
    #1;
    chk("reset_load", Load, 0);
    chk("reset_dout", DataOut, 0);
    chk("reset_sel", SelIndex, 0);
    chk("reset_busy", Busy, 0);
    @(negedge Clock);
    Reset = 1'b0;
    sel_m = 2'd0;
    repeat (GAP) @(negedge Clock);
    chk("post_reset_quiet", Load, 0);

    press(4'h5, 4'h5, 40);
    chk("post_reset_sel", SelIndex, 1);

    repeat (20) @(negedge Clock);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
